branch_predictor: RTL and testbench

//   Parametrised dynamic branch predictor for the 5-stage pipeline. Successor to the

---
 rtl/branch_predictor.sv | 105 ++++++++++
 tb/tb_branch_predictor.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: static not-taken, bimodal or gshare pattern table,
// registered 1-cycle lookup at IF, non-speculative update at resolve, perf counters.
module branch_predictor #(
    parameter  int ADDR_W  = 32,
    parameter  int ENTRIES = 64,
    parameter  int CTR_W   = 2,
    parameter  int MODE    = 1,
    parameter  int GHR_W   = 6,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              lookup_i,
    input  logic [ADDR_W-1:0] pc_i,
    output logic              pred_taken_o,
    output logic [IDX_W-1:0]  pred_idx_o,
    input  logic              upd_valid_i,
    input  logic [IDX_W-1:0]  upd_idx_i,
    input  logic              upd_taken_i,
    input  logic              upd_mispred_i,
    output logic [31:0]       branch_cnt_o,
    output logic [31:0]       mispred_cnt_o
);

    typedef logic [CTR_W-1:0] ctr_t;

    localparam ctr_t CTR_INIT = ctr_t'((1 << (CTR_W - 1)) - 1);
    localparam ctr_t CTR_MAX  = '1;

    ctr_t             table_q [ENTRIES];
    ctr_t             table_d [ENTRIES];
    logic [GHR_W-1:0] ghr_q, ghr_d;
    logic             pred_taken_q, pred_taken_d;
    logic [IDX_W-1:0] pred_idx_q, pred_idx_d;
    logic [31:0]      branch_cnt_q, branch_cnt_d;
    logic [31:0]      mispred_cnt_q, mispred_cnt_d;

    logic [IDX_W-1:0] base_idx;
    logic [IDX_W-1:0] lookup_idx;
    ctr_t             upd_ctr;

    // Byte offset and PC bits above the table index do not take part in indexing.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc_i[ADDR_W-1:IDX_W+2], pc_i[1:0]};

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        base_idx   = pc_i[IDX_W+1:2];
        lookup_idx = (MODE == 2) ? (base_idx ^ IDX_W'(ghr_q)) : base_idx;

        pred_taken_d = pred_taken_q;
        pred_idx_d   = pred_idx_q;
        if (lookup_i && !stall_i) begin
            pred_idx_d   = lookup_idx;
            pred_taken_d = (MODE == 0) ? 1'b0 : table_q[lookup_idx][CTR_W-1];
        end

        // Lookup above reads table_q, so a same-edge update is not bypassed.
        table_d = table_q;
        upd_ctr = table_q[upd_idx_i];
        if (upd_valid_i && (MODE != 0)) begin
            if (upd_taken_i && (upd_ctr != CTR_MAX)) begin
                table_d[upd_idx_i] = upd_ctr + ctr_t'(1);
            end else if (!upd_taken_i && (upd_ctr != '0)) begin
                table_d[upd_idx_i] = upd_ctr - ctr_t'(1);
            end
        end

        ghr_d = ghr_q;
        if (upd_valid_i && (MODE == 2)) begin
            ghr_d = GHR_W'({ghr_q, upd_taken_i});
        end

        branch_cnt_d  = branch_cnt_q + {31'd0, upd_valid_i};
        mispred_cnt_d = mispred_cnt_q + {31'd0, upd_valid_i & upd_mispred_i};
    end

    // NOTE: the pattern table is reset as well, because prediction must restart from weakly not-taken.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= CTR_INIT;
            end
            ghr_q         <= '0;
            pred_taken_q  <= 1'b0;
            pred_idx_q    <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            table_q       <= table_d;
            ghr_q         <= ghr_d;
            pred_taken_q  <= pred_taken_d;
            pred_idx_q    <= pred_idx_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign pred_taken_o  = pred_taken_q;
    assign pred_idx_o    = pred_idx_q;
    assign branch_cnt_o  = branch_cnt_q;
    assign mispred_cnt_o = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench: a bimodal and a gshare (GHR_W=3) predictor share stimulus and are
// compared every cycle against a counter/history reference model kept in plain ints.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        lookup = 1'b0;
    logic [31:0] pc = '0;
    logic        upd_valid = 1'b0;
    logic [5:0]  upd_idx = '0;
    logic        upd_taken = 1'b0;
    logic        upd_mispred = 1'b0;

    logic        pt_b, pt_g;
    logic [5:0]  pi_b, pi_g;
    logic [31:0] bc_b, bc_g, mc_b, mc_g;

    int ctr [2][64];
    int ghr;
    int e_taken [2];
    int e_idx [2];
    int e_bcnt, e_mcnt;
    int n_checks = 0;
    int n_pass = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    branch_predictor dut_b (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .lookup_i(lookup), .pc_i(pc),
        .pred_taken_o(pt_b), .pred_idx_o(pi_b),
        .upd_valid_i(upd_valid), .upd_idx_i(upd_idx), .upd_taken_i(upd_taken),
        .upd_mispred_i(upd_mispred), .branch_cnt_o(bc_b), .mispred_cnt_o(mc_b)
    );

    branch_predictor #(.MODE(2), .GHR_W(3)) dut_g (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .lookup_i(lookup), .pc_i(pc),
        .pred_taken_o(pt_g), .pred_idx_o(pi_g),
        .upd_valid_i(upd_valid), .upd_idx_i(upd_idx), .upd_taken_i(upd_taken),
        .upd_mispred_i(upd_mispred), .branch_cnt_o(bc_g), .mispred_cnt_o(mc_g)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 64; i++) ctr[d][i] = 1;
            e_taken[d] = 0;
            e_idx[d]   = 0;
        end
        ghr    = 0;
        e_bcnt = 0;
        e_mcnt = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, " bim taken"}, {31'd0, pt_b}, e_taken[0]);
        check({tag, " bim idx"},   {26'd0, pi_b}, e_idx[0]);
        check({tag, " bim bcnt"},  bc_b, e_bcnt);
        check({tag, " bim mcnt"},  mc_b, e_mcnt);
        check({tag, " gsh taken"}, {31'd0, pt_g}, e_taken[1]);
        check({tag, " gsh idx"},   {26'd0, pi_g}, e_idx[1]);
        check({tag, " gsh bcnt"},  bc_g, e_bcnt);
        check({tag, " gsh mcnt"},  mc_g, e_mcnt);
    endtask

    // Advance the model by one edge using the inputs now applied, then compare after the edge.
    task automatic tick(input string tag);
        int base;
        int idx;
        if (lookup && !stall) begin
            base = int'((pc / 4) % 64);
            for (int d = 0; d < 2; d++) begin
                idx        = (d == 1) ? (base ^ ghr) : base;
                e_idx[d]   = idx;
                e_taken[d] = (ctr[d][idx] >= 2) ? 1 : 0;
            end
        end
        if (upd_valid) begin
            for (int d = 0; d < 2; d++) begin
                if (upd_taken) ctr[d][upd_idx] = (ctr[d][upd_idx] < 3) ? ctr[d][upd_idx] + 1 : 3;
                else           ctr[d][upd_idx] = (ctr[d][upd_idx] > 0) ? ctr[d][upd_idx] - 1 : 0;
            end
            ghr = (ghr * 2 + (upd_taken ? 1 : 0)) % 8;
            e_bcnt++;
            if (upd_mispred) e_mcnt++;
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic upd(input int idx, input bit taken, input bit mis);
        lookup      = 1'b0;
        upd_valid   = 1'b1;
        upd_idx     = 6'(idx);
        upd_taken   = taken;
        upd_mispred = mis;
        tick("upd");
        upd_valid   = 1'b0;
        upd_mispred = 1'b0;
    endtask

    task automatic look(input logic [31:0] addr);
        lookup = 1'b1;
        pc     = addr;
        tick("look");
        lookup = 1'b0;
    endtask

    // Reset pulse placed strictly between rising edges; outputs must clear before the next edge.
    task automatic async_reset();
        lookup    = 1'b0;
        upd_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("async rst");
        #1 rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        #12;
        check_all("reset");
        rst = 1'b0;

        // Reset release then first lookup
        look(32'h40);
        check("first idx", {26'd0, pi_b}, 32'h10);

        // Saturation on idx 5
        upd(5, 1, 0);
        upd(5, 1, 0);
        look(32'h14);
        check("sat 2T", {31'd0, pt_b}, 1);
        for (int i = 0; i < 5; i++) upd(5, 1, 0);
        look(32'h14);
        check("sat 7T", {31'd0, pt_b}, 1);
        upd(5, 0, 0);
        look(32'h14);
        check("sat 1NT", {31'd0, pt_b}, 1);
        upd(5, 0, 0);
        look(32'h14);
        check("sat 2NT", {31'd0, pt_b}, 0);

        // Same-edge collision on idx 3
        upd_valid = 1'b1;
        upd_idx   = 6'd3;
        upd_taken = 1'b1;
        lookup    = 1'b1;
        pc        = 32'h0C;
        tick("collide");
        upd_valid = 1'b0;
        lookup    = 1'b0;
        check("collide pre", {31'd0, pt_b}, 0);
        look(32'h0C);
        check("collide post", {31'd0, pt_b}, 1);

        // Stall freezes outputs
        upd(5, 1, 0);
        upd(5, 1, 0);
        look(32'h14);
        check("stall setup", {31'd0, pt_b}, 1);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            lookup = (i % 2 == 0);
            pc     = $urandom & 32'hFFFF_FFFC;
            tick("stall");
            check("stall idx", {26'd0, pi_b}, 5);
            check("stall taken", {31'd0, pt_b}, 1);
        end
        stall  = 1'b0;
        lookup = 1'b0;

        // gshare history T,T,NT -> 3'b110
        upd(0, 1, 0);
        upd(0, 1, 0);
        upd(0, 0, 0);
        look(32'h0);
        check("gshare idx", {26'd0, pi_g}, 6);

        // Perf counters and async reset
        async_reset();
        for (int i = 0; i < 10; i++) upd(i + 10, i[0], i < 3);
        check("branch cnt", bc_b, 10);
        check("mispred cnt", mc_b, 3);
        async_reset();
        look(32'h14);
        check("post rst weak NT", {31'd0, pt_b}, 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            stall       = ($urandom_range(0, 3) == 0);
            lookup      = ($urandom_range(0, 1) == 1);
            pc          = $urandom & 32'hFFFF_FFFC;
            upd_valid   = ($urandom_range(0, 2) != 0);
            upd_idx     = 6'($urandom_range(0, 63));
            upd_taken   = ($urandom_range(0, 1) == 1);
            upd_mispred = ($urandom_range(0, 3) == 0);
            tick("random");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
